// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: funct3 encodings and FSM state shared by the branch resolve logic
package branch_resolve_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_e;
endpackage

// File: rtl/branch_resolve_cond.sv
// branch_cond: combinational taken/illegal decode from funct3 and the comparator bit
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cmp_lsb,
  input  logic       is_jump,
  output logic       taken,
  output logic       illegal
);
  logic pos, neg;
  always_comb begin
    pos = funct3 inside {F3_BEQ, F3_BLT, F3_BLTU};
    neg = funct3 inside {F3_BNE, F3_BGE, F3_BGEU};
    taken = is_jump || (pos && cmp_lsb) || (neg && !cmp_lsb);
    illegal = !is_jump && !pos && !neg;
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves branches, drives the fetch redirect handshake and a timed flush
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int AW = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic              br_is_jump,
  input  logic [2:0]        br_funct3,
  input  logic              cmp_lsb,
  input  logic [AW-1:0]     br_target,
  output logic              redirect_valid,
  output logic [AW-1:0]     redirect_pc,
  input  logic              redirect_ack,
  output logic              flush,
  output logic              misalign,
  output logic              illegal,
  output logic [STAT_W-1:0] taken_cnt
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES > 0 ? FLUSH_CYCLES - 1 : 0);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [STAT_W-1:0] tc_q, tc_d;
  logic rv_q, rv_d, flush_q, flush_d, mis_q, mis_d, ill_q, ill_d;
  logic taken, bad_f3, aligned;
  branch_cond u_cond (
    .funct3 (br_funct3),
    .cmp_lsb(cmp_lsb),
    .is_jump(br_is_jump),
    .taken  (taken),
    .illegal(bad_f3)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pc_d = pc_q;
    tc_d = tc_q;
    rv_d = rv_q;
    flush_d = flush_q;
    mis_d = 1'b0;
    ill_d = 1'b0;
    aligned = br_target[1:0] == 2'b00;
    case (state_q)
      IDLE: if (br_valid) begin
        ill_d = bad_f3;
        mis_d = taken && !aligned;
        if (taken && aligned) begin
          rv_d = 1'b1;
          pc_d = br_target;
          tc_d = &tc_q ? tc_q : tc_q + STAT_W'(1);
          state_d = REDIRECT;
        end
      end
      REDIRECT: if (redirect_ack) begin
        rv_d = 1'b0;
        flush_d = FLUSH_CYCLES != 0;
        cnt_d = CNT_INIT;
        state_d = FLUSH_CYCLES != 0 ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush_d = cnt_q != '0;
        cnt_d = cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
        state_d = cnt_q != '0 ? FLUSH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pc_q <= '0;
      tc_q <= '0;
      rv_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      tc_q <= tc_d;
      rv_q <= rv_d;
      flush_q <= flush_d;
      mis_q <= mis_d;
      ill_q <= ill_d;
    end
  end
  assign br_ready = state_q == IDLE;
  assign redirect_valid = rv_q;
  assign redirect_pc = pc_q;
  assign flush = flush_q;
  assign misalign = mis_q;
  assign illegal = ill_q;
  assign taken_cnt = tc_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vector table plus hand sequences for handshake, flush and reset corners
module tb_branch_resolve;
  logic clk = 1'b0, rst_n = 1'b0;
  logic br_valid = 1'b0, br_is_jump = 1'b0, cmp_lsb = 1'b0, redirect_ack = 1'b0;
  logic [2:0] br_funct3 = 3'b000;
  logic [31:0] br_target = '0;
  logic rdy, rv, fl, mis, ill;
  logic [31:0] pc;
  logic [15:0] cnt;
  logic rdy0, rv0, fl0, mis0, ill0;
  logic [31:0] pc0;
  logic [15:0] cnt0;
  logic rdy2, rv2, fl2, mis2, ill2;
  logic [31:0] pc2;
  logic [1:0] cnt2;
  int total = 0, bad = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy), .br_is_jump(br_is_jump),
    .br_funct3(br_funct3), .cmp_lsb(cmp_lsb), .br_target(br_target), .redirect_valid(rv),
    .redirect_pc(pc), .redirect_ack(redirect_ack), .flush(fl), .misalign(mis), .illegal(ill),
    .taken_cnt(cnt)
  );
  branch_resolve #(.FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy0), .br_is_jump(br_is_jump),
    .br_funct3(br_funct3), .cmp_lsb(cmp_lsb), .br_target(br_target), .redirect_valid(rv0),
    .redirect_pc(pc0), .redirect_ack(redirect_ack), .flush(fl0), .misalign(mis0), .illegal(ill0),
    .taken_cnt(cnt0)
  );
  branch_resolve #(.STAT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy2), .br_is_jump(br_is_jump),
    .br_funct3(br_funct3), .cmp_lsb(cmp_lsb), .br_target(br_target), .redirect_valid(rv2),
    .redirect_pc(pc2), .redirect_ack(redirect_ack), .flush(fl2), .misalign(mis2), .illegal(ill2),
    .taken_cnt(cnt2)
  );
  typedef struct {
    logic j;
    logic [2:0] f3;
    logic c;
    logic [31:0] t;
    logic redir;
    logic mis;
    logic ill;
  } vec_t;
  vec_t vt[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic issue(input logic j, input logic [2:0] f, input logic c, input logic [31:0] t);
    @(negedge clk);
    br_is_jump = j;
    br_funct3 = f;
    cmp_lsb = c;
    br_target = t;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
  endtask
  task automatic check_cnt();
    check("taken_cnt", cnt, exp_cnt);
    check("taken_cnt_sat", cnt2, exp_cnt > 3 ? 3 : exp_cnt);
  endtask
  task automatic ack_and_flush();
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("ack_rv_drop", rv, 0);
    check("flush_c1", fl, 1);
    check("fc0_rv_drop", rv0, 0);
    check("fc0_ready", rdy0, 1);
    check("fc0_no_flush", fl0, 0);
    @(negedge clk);
    check("flush_c2", fl, 1);
    check("flush_not_ready", rdy, 0);
    check("fc0_no_flush2", fl0, 0);
    @(negedge clk);
    check("flush_end", fl, 0);
    check("ready_after_flush", rdy, 1);
  endtask
  initial begin
    vt[0]  = '{1'b0, 3'b001, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 3'b111, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 3'b010, 1'b0, 32'h102, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 3'b011, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 3'b010, 1'b1, 32'h106, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 3'b100, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 3'b101, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 3'b101, 1'b0, 32'h604, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'b110, 1'b1, 32'h006, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 3'b110, 1'b0, 32'h700, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 3'b000, 1'b0, 32'h800, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 3'b000, 1'b0, 32'h900, 1'b1, 1'b0, 1'b0};
    #12;
    check("ready_in_reset", rdy, 1);
    check("rst_rv", rv, 0);
    check("rst_flush", fl, 0);
    check("rst_pc", pc, 0);
    check("rst_misalign", mis, 0);
    check("rst_illegal", ill, 0);
    check_cnt();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 3'b000, 1'b1, 32'h100);
    exp_cnt++;
    check("beq_rv", rv, 1);
    check("beq_pc", pc, 32'h100);
    check("beq_ready_low", rdy, 0);
    check_cnt();
    @(negedge clk);
    check("beq_rv_hold", rv, 1);
    check("beq_pc_hold", pc, 32'h100);
    check("beq_no_flush_yet", fl, 0);
    ack_and_flush();
    foreach (vt[i]) begin
      issue(vt[i].j, vt[i].f3, vt[i].c, vt[i].t);
      if (vt[i].redir) exp_cnt++;
      check($sformatf("v%0d_rv", i), rv, vt[i].redir);
      check($sformatf("v%0d_mis", i), mis, vt[i].mis);
      check($sformatf("v%0d_ill", i), ill, vt[i].ill);
      check($sformatf("v%0d_ready", i), rdy, !vt[i].redir);
      check($sformatf("v%0d_fc0_rv", i), rv0, vt[i].redir);
      check($sformatf("v%0d_flush", i), fl, 0);
      check_cnt();
      if (vt[i].redir) begin
        check($sformatf("v%0d_pc", i), pc, vt[i].t);
        ack_and_flush();
      end
      @(negedge clk);
      check($sformatf("v%0d_mis_pulse", i), mis, 0);
      check($sformatf("v%0d_ill_pulse", i), ill, 0);
      check($sformatf("v%0d_idle_rv", i), rv, 0);
    end
    issue(1'b0, 3'b100, 1'b1, 32'hA00);
    exp_cnt++;
    check_cnt();
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("pre_rst_flush", fl, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flush", fl, 0);
    check("async_rst_ready", rdy, 1);
    exp_cnt = 0;
    check_cnt();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 3'b100, 1'b1, 32'hB00);
    exp_cnt++;
    check("post_rst_rv", rv, 1);
    check("post_rst_pc", pc, 32'hB00);
    check_cnt();
    ack_and_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Control-side consumer of the single compare bit produced by the ALU/comparator LSB path for branch instructions.
- Combines that bit with funct3 to decide taken / not-taken, and latches the branch target.
- Drives a redirect handshake to fetch, then holds a pipeline flush for a programmable number of cycles.
- Also flags misaligned targets and keeps a saturating taken-branch counter for debug.

Parameters:
- AW, 32, address width of branch target and redirect PC.
- FLUSH_CYCLES, 2, cycles flush stays high after redirect is acknowledged; 0 means no flush phase.
- STAT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- br_valid  input  1  resolve request: branch/jump in execute this cycle.
- br_ready  output  1  block can accept a request. High only in IDLE, including while in reset.
- br_is_jump  input  1  unconditional (JAL/JALR); overrides funct3 and cmp_lsb.
- br_funct3  input  3  RV32 branch funct3.
- cmp_lsb  input  1  compare result bit; 1 = eq (BEQ/BNE), lt (BLT/BGE), ltu (BLTU/BGEU).
- br_target  input  AW  computed target address.
- redirect_valid  output  1  registered; new PC pending to fetch.
- redirect_pc  output  AW  registered; target held stable while redirect_valid=1.
- redirect_ack  input  1  fetch accepted the redirect.
- flush  output  1  registered; kill younger pipeline stages.
- misalign  output  1  registered 1-cycle pulse: taken target with br_target[1:0] != 0.
- illegal  output  1  registered 1-cycle pulse: funct3 010 or 011 on a non-jump request.
- taken_cnt  output  STAT_W  registered saturating count of redirects issued.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - redirect_valid, flush, misalign, illegal = 0; redirect_pc = 0; taken_cnt = 0; flush counter = 0.
  - Reset mid-REDIRECT or mid-FLUSH aborts immediately; no ack is required afterwards.
- Accept condition: br_valid && br_ready (IDLE only). br_valid in any other state is ignored; upstream must hold it.
- Taken decode:
  - br_is_jump → taken = 1.
  - Otherwise: 000 → cmp_lsb; 001 → !cmp_lsb; 100 and 110 → cmp_lsb; 101 and 111 → !cmp_lsb.
  - 010 / 011 → taken = 0, illegal pulses next cycle.
- IDLE, on accept (outputs appear on the next edge, latency 1):
  - not taken → stay IDLE, no outputs.
  - taken && br_target[1:0] != 0 → misalign = 1 for one cycle; no redirect; stay IDLE.
  - taken && aligned → redirect_pc = br_target, redirect_valid = 1, go to REDIRECT, taken_cnt += 1 (saturates at all-ones).
- REDIRECT:
  - Hold redirect_valid = 1 and redirect_pc until redirect_ack = 1. The ack may arrive in the first REDIRECT cycle.
  - On ack: redirect_valid = 0 next edge.
    - FLUSH_CYCLES > 0 → flush = 1, counter = FLUSH_CYCLES−1, go to FLUSH.
    - FLUSH_CYCLES = 0 → go to IDLE.
- FLUSH:
  - flush = 1. Counter decrements each cycle.
  - When counter = 0: flush = 0 next edge and go to IDLE. flush is high for exactly FLUSH_CYCLES cycles.
- redirect_ack outside REDIRECT is ignored.
- br_ready = (state == IDLE), combinational from state. It goes low the cycle after a taken, aligned accept.

Decomposition:
- Shared package holds:
  - funct3 constants BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - State enum IDLE/REDIRECT/FLUSH (2-bit).
- Sub-module: branch_cond. Purely combinational; inputs funct3, cmp_lsb, is_jump; outputs taken, illegal. Reusable by a later branch predictor checker.

Test Plan:
- BEQ, cmp_lsb=1, target 0x0000_0100, ack on 2nd REDIRECT cycle → redirect_valid high 2 cycles with redirect_pc=0x100; flush high exactly 2 cycles; taken_cnt=1; br_ready back high after flush.
- BNE, cmp_lsb=1 → no redirect, no flush, br_ready stays 1, taken_cnt unchanged. Then BGEU, cmp_lsb=0, ack immediately → redirect taken.
- br_is_jump=1, funct3=010, target 0x0000_0102 → misalign pulse 1 cycle, no illegal, no redirect, state IDLE. Non-jump funct3=011 → illegal pulse only.
- rst_n low while in FLUSH with counter=1 → flush drops asynchronously, taken_cnt=0, br_ready=1. After release, a new BLT request is accepted normally.
- FLUSH_CYCLES=0 build: taken BLTU with immediate ack → REDIRECT one cycle, then IDLE, flush never asserted.
- STAT_W=2: four taken redirects → taken_cnt reads 1,2,3,3 (saturates).
